// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM slave controller.
package sram_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

endpackage

// File: rtl/sram_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module sram_array
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Contents are deliberately not reset; the controller's sweep clears them.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_ctrl.sv
// SRAM slave controller: zero-fill sweep after reset, then one read or write
// per valid/ready handshake with a programmable number of wait states.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned INIT_ZERO   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_rd,
   input  logic              valid,
   output logic              ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              init_done
);

   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam int unsigned WCNT_W  = 4;
   localparam state_t      RST_ST  = (INIT_ZERO != 0) ? INIT : IDLE;
   localparam logic        RST_IDN = (INIT_ZERO == 0);

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_sweep;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_wr_rd;
   logic                r_ready;
   logic                r_init_done;

   logic                w_we;
   logic                w_re;
   logic [ADDR_W-1:0]   w_waddr;
   logic [DATA_W-1:0]   w_wdata;
   logic                w_sweep_last;
   logic                w_wait_done;

   assign w_sweep_last = (r_sweep == ADDR_W'(DEPTH - 1));
   assign w_wait_done  = (r_wcnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RST_ST;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state plus the array port mux: sweep writes in INIT, request access in WAIT.
   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_re    = 1'b0;
      w_waddr = r_addr;
      w_wdata = r_wdata;
      case (r_state)
         INIT: begin
            w_we    = 1'b1;
            w_waddr = r_sweep;
            w_wdata = '0;
            if (w_sweep_last) begin
               w_next = IDLE;
            end
         end
         IDLE: begin
            if (valid) begin
               w_next = WAIT;
            end
         end
         WAIT: begin
            if (w_wait_done) begin
               w_next = RESP;
               w_we   = (r_wr_rd == WR);
               w_re   = (r_wr_rd == RD);
            end
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = RST_ST;
         end
      endcase
   end

   // Sweep counter, wait counter, request capture and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sweep     <= '0;
         r_wcnt      <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wr_rd     <= RD;
         r_ready     <= 1'b0;
         r_init_done <= RST_IDN;
      end else begin
         r_ready <= (r_state == WAIT) && w_wait_done;
         if (r_state == INIT) begin
            r_sweep <= r_sweep + ADDR_W'(1);
            if (w_sweep_last) begin
               r_init_done <= 1'b1;
            end
         end
         if ((r_state == IDLE) && valid) begin
            r_addr  <= addr;
            r_wdata <= wr_data;
            r_wr_rd <= wr_rd;
            r_wcnt  <= WCNT_W'(WAIT_STATES);
         end
         if ((r_state == WAIT) && !w_wait_done) begin
            r_wcnt <= r_wcnt - WCNT_W'(1);
         end
      end
   end

   sram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_re),
      .i_raddr (r_addr),
      .o_rdata (rd_data)
   );

   assign ready     = r_ready;
   assign init_done = r_init_done;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance with no wait states, one with three.
module tb_sram_ctrl;
   import sram_pkg::*;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_rd = 1'b0;
   logic          valid0 = 1'b0;
   logic          valid1 = 1'b0;
   logic          ready0, ready1, init0, init1;
   logic [DW-1:0] rd0, rd1;

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0), .INIT_ZERO(1)) u_dut (
      .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_rd(wr_rd),
      .valid(valid0), .ready(ready0), .rd_data(rd0), .init_done(init0)
   );

   sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(3), .INIT_ZERO(1)) u_dut_w3 (
      .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_rd(wr_rd),
      .valid(valid1), .ready(ready1), .rd_data(rd1), .init_done(init1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request, return data and the number of edges until ready is seen.
   task automatic txn(input bit sel, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic [DW-1:0] q, output int lat);
      addr    = a;
      wr_data = d;
      wr_rd   = w;
      if (sel) valid1 = 1'b1;
      else     valid0 = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (((sel ? ready1 : ready0) == 1'b0) && lat < 20);
      q      = sel ? rd1 : rd0;
      valid0 = 1'b0;
      valid1 = 1'b0;
      tick();
      chk("ready_single_cycle", 32'(sel ? ready1 : ready0), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] q;
      int            lat;
      int            n;
      bit            early;

      // Reset state
      repeat (3) tick();
      chk("rst_ready0", 32'(ready0), 32'd0);
      chk("rst_rd0",    32'(rd0),    32'd0);
      chk("rst_init0",  32'(init0),  32'd0);
      chk("rst_ready1", 32'(ready1), 32'd0);
      chk("rst_init1",  32'(init1),  32'd0);

      // Read of 0x05 pending from reset release; sweep takes 256 edges
      addr   = 8'h05;
      wr_rd  = RD;
      valid0 = 1'b1;
      rst    = 1'b1;
      early  = 1'b0;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (ready0 || ready1) early = 1'b1;
      end
      chk("no_ready_in_sweep", 32'(early), 32'd0);
      chk("init0_edge255", 32'(init0), 32'd0);
      chk("init1_edge255", 32'(init1), 32'd0);
      tick();
      chk("init0_edge256", 32'(init0), 32'd1);
      chk("init1_edge256", 32'(init1), 32'd1);
      chk("ready_at_init", 32'(ready0), 32'd0);
      tick();
      chk("pending_capture", 32'(ready0), 32'd0);
      tick();
      chk("pending_ready", 32'(ready0), 32'd1);
      chk("pending_data",  32'(rd0),    32'h0000);
      valid0 = 1'b0;
      tick();
      chk("pending_single", 32'(ready0), 32'd0);

      // Zero-filled reads at low, middle and top addresses
      txn(1'b0, RD, 8'h00, 16'h0, q, lat);
      chk("rd00_lat", 32'(lat), 32'd2);
      chk("rd00_data", 32'(q), 32'h0000);
      txn(1'b0, RD, 8'h7F, 16'h0, q, lat);
      chk("rd7f_data", 32'(q), 32'h0000);
      txn(1'b0, RD, 8'hFF, 16'h0, q, lat);
      chk("rdff_data", 32'(q), 32'h0000);

      // Write/read and rd_data hold across a write
      txn(1'b0, WR, 8'h10, 16'hA5A5, q, lat);
      chk("wr10_lat", 32'(lat), 32'd2);
      txn(1'b0, RD, 8'h10, 16'h0, q, lat);
      chk("rd10_data", 32'(q), 32'hA5A5);
      txn(1'b0, WR, 8'h11, 16'h1234, q, lat);
      chk("hold_during_wr", 32'(q), 32'hA5A5);
      chk("hold_after_wr", 32'(rd0), 32'hA5A5);
      txn(1'b0, RD, 8'h11, 16'h0, q, lat);
      chk("rd11_data", 32'(q), 32'h1234);

      // Back-to-back writes with valid held; master advances on the ready edge
      addr    = 8'hFC;
      wr_data = 16'h0001;
      wr_rd   = WR;
      valid0  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!ready0 && n < 20);
         chk("b2b_gap", 32'(n), (k == 0) ? 32'd2 : 32'd3);
         if (k < 3) begin
            addr    = 8'(8'hFD + k);
            wr_data = 16'(k + 2);
         end else begin
            valid0 = 1'b0;
         end
      end
      early = 1'b0;
      repeat (5) begin
         tick();
         if (ready0) early = 1'b1;
      end
      chk("b2b_no_extra", 32'(early), 32'd0);
      for (int k = 0; k < 4; k++) begin
         txn(1'b0, RD, 8'(8'hFC + k), 16'h0, q, lat);
         chk("b2b_readback", 32'(q), 32'(k + 1));
      end

      // Three wait states: ready five edges after the drive point
      txn(1'b1, RD, 8'h20, 16'h0, q, lat);
      chk("w3_rd_lat", 32'(lat), 32'd5);
      chk("w3_rd_data", 32'(q), 32'h0000);
      txn(1'b1, WR, 8'h20, 16'h5A5A, q, lat);
      chk("w3_wr_lat", 32'(lat), 32'd5);
      txn(1'b1, RD, 8'h20, 16'h0, q, lat);
      chk("w3_rd_back", 32'(q), 32'h5A5A);

      // Reset while a write sits in WAIT: write lost, earlier commit swept away
      txn(1'b0, WR, 8'h31, 16'h1111, q, lat);
      addr    = 8'h30;
      wr_data = 16'hBEEF;
      wr_rd   = WR;
      valid0  = 1'b1;
      tick();
      chk("mid_wait_ready", 32'(ready0), 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(ready0), 32'd0);
      chk("rst_mid_init",  32'(init0),  32'd0);
      valid0 = 1'b0;
      #1 rst = 1'b1;
      n = 0;
      early = 1'b0;
      do begin
         tick();
         n++;
         if (ready0) early = 1'b1;
      end while (!init0 && n < 300);
      chk("resweep_len", 32'(n), 32'd256);
      chk("resweep_no_ready", 32'(early), 32'd0);
      txn(1'b0, RD, 8'h30, 16'h0, q, lat);
      chk("lost_write", 32'(q), 32'h0000);
      txn(1'b0, RD, 8'h31, 16'h0, q, lat);
      chk("swept_commit", 32'(q), 32'h0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
